// File: rtl/sd_cmd_master_queued.sv
// Queued SD command master: buffers host commands and runs each one through the serial
// command engine with response CRC/index checks, CRC retry, a watchdog and card-detect debounce.
module sd_cmd_master_queued #(
    parameter int QDEPTH      = 4,
    parameter int TO_W        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int MAX_RETRY   = 2
) (
    input  logic                    CLK_PAD_IO,
    input  logic                    RST_PAD_I,
    input  logic                    cmd_push,
    input  logic [31:0]             cmd_arg,
    input  logic [13:0]             cmd_set,
    input  logic                    data_read,
    input  logic                    data_write,
    input  logic [TO_W-1:0]         TIMEOUT_REG,
    output logic                    q_full,
    output logic [$clog2(QDEPTH):0] q_level,
    output logic [39:0]             cmd_out,
    output logic [15:0]             settings,
    output logic                    req_out,
    input  logic                    ack_in,
    input  logic                    req_in,
    output logic                    ack_out,
    input  logic [7:0]              serial_status,
    input  logic [39:0]             cmd_in,
    output logic                    resp_valid,
    output logic [31:0]             resp_data,
    output logic [5:0]              resp_index,
    output logic [4:0]              err_flags,
    output logic                    go_idle_o,
    input  logic                    card_detect,
    output logic                    card_present
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ISSUED, S_EXECUTE, S_ACKWAIT, S_DONE
    } state_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [1:0]  wsel;
        logic        cice;
        logic        crce;
        logic [1:0]  rts;
        logic        rd;
        logic        wr;
        logic [31:0] arg;
    } entry_t;

    function automatic logic [6:0] resp_size(input logic [1:0] rts);
        case (rts)
            2'b00:   return 7'd0;
            2'b01:   return 7'd127;
            default: return 7'd40;
        endcase
    endfunction

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] ack_sync, req_sync;
    logic                   ack_s, req_s;

    entry_t         q_mem [QDEPTH];
    entry_t         head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push_ok, pop, load_head;

    logic [TO_W-1:0] wd_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            reissue, cur_cice;
    logic [1:0]      cur_rts;
    logic            watch, expire, eval, crc_bad, idx_bad, can_retry;
    logic            ack_next, req_next;
    logic [DEB_W-1:0] deb_cnt;

    logic unused_bits;
    assign unused_bits = ^{cmd_set[5], cmd_set[2], serial_status[7], serial_status[4:0], cmd_in[39:38]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            ack_sync <= '0;
            req_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign req_s = req_sync[SYNC_STAGES-1];

    assign q_full    = (count == CW'(QDEPTH));
    assign q_level   = count;
    assign push_ok   = cmd_push & ~q_full;
    assign pop       = (state == S_DONE);
    assign head      = q_mem[rd_ptr];
    assign load_head = (state == S_IDLE) && (count != '0);

    // NOTE: queue storage has no reset; an entry is never read before it has been written.
    always_ff @(posedge CLK_PAD_IO) begin
        if (push_ok)
            q_mem[wr_ptr] <= '{idx: cmd_set[13:8], wsel: cmd_set[7:6], cice: cmd_set[4],
                               crce: cmd_set[3], rts: cmd_set[1:0], rd: data_read,
                               wr: data_write, arg: cmd_arg};
    end

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign watch     = (state == S_ISSUED) || (state == S_EXECUTE) || (state == S_ACKWAIT);
    assign expire    = watch && (wd_cnt > TIMEOUT_REG);
    assign eval      = (state == S_EXECUTE) && !expire && req_s && !ack_out && serial_status[6];
    assign crc_bad   = settings[7] && !serial_status[5];
    assign idx_bad   = cur_cice && (cmd_in[37:32] != cmd_out[37:32]);
    assign can_retry = crc_bad && (retry_cnt < RETRY_LIM);

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) state <= S_IDLE;
        else           state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        ack_next   = 1'b0;
        case (state)
            S_IDLE:    if (count != '0) next_state = S_SETUP;
            S_SETUP:   if (ack_s) next_state = S_ISSUED;
            S_ISSUED:  if (expire) next_state = S_DONE;
                       else if (!ack_s) next_state = S_EXECUTE;
            S_EXECUTE: begin
                if (expire) next_state = S_DONE;
                else begin
                    ack_next = req_s;
                    if (eval) next_state = S_ACKWAIT;
                end
            end
            S_ACKWAIT: begin
                if (expire) next_state = S_DONE;
                else begin
                    ack_next = req_s;
                    if (!req_s) next_state = reissue ? S_SETUP : S_DONE;
                end
            end
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        req_next = (next_state == S_SETUP);
    end

    assign resp_valid = (state == S_DONE);
    assign go_idle_o  = expire;

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            cmd_out    <= '0;
            settings   <= '0;
            cur_cice   <= 1'b0;
            cur_rts    <= 2'b00;
            resp_index <= '0;
            resp_data  <= '0;
            err_flags  <= '0;
            retry_cnt  <= '0;
            reissue    <= 1'b0;
            wd_cnt     <= '0;
            req_out    <= 1'b0;
            ack_out    <= 1'b0;
        end else begin
            req_out <= req_next;
            ack_out <= ack_next;
            if (load_head) begin
                cmd_out    <= {2'b01, head.idx, head.arg};
                settings   <= {1'b0, head.wsel, head.rd, head.wr, 3'b111, head.crce, resp_size(head.rts)};
                cur_cice   <= head.cice;
                cur_rts    <= head.rts;
                resp_index <= head.idx;
                resp_data  <= '0;
                err_flags  <= '0;
            end
            if (state == S_SETUP)
                wd_cnt <= '0;
            else if (watch && (wd_cnt != '1))
                wd_cnt <= wd_cnt + TO_W'(1);
            // Flags accumulate across reissues; only the CRC bit tracks the latest attempt.
            if (eval) begin
                resp_data    <= (cur_rts == 2'b00) ? 32'd0 : cmd_in[31:0];
                err_flags[1] <= crc_bad;
                err_flags[3] <= err_flags[3] | idx_bad;
                err_flags[4] <= err_flags[4] | (crc_bad && (retry_cnt == RETRY_LIM));
                reissue      <= can_retry;
                if (can_retry) retry_cnt <= retry_cnt + RW'(1);
            end
            if (expire) err_flags[0] <= 1'b1;
            if (state == S_DONE) retry_cnt <= '0;
        end
    end

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            deb_cnt      <= '0;
            card_present <= 1'b0;
        end else begin
            if (card_detect)          deb_cnt <= '0;
            else if (deb_cnt != '1)   deb_cnt <= deb_cnt + DEB_W'(1);
            card_present <= (deb_cnt == '1);
        end
    end

endmodule

// File: tb/tb_sd_cmd_master_queued.sv
// Directed bench for sd_cmd_master_queued: a small serial-engine model drives the
// handshakes while a scoreboard of expected commands and completions is checked in order.
module tb_sd_cmd_master_queued;
    localparam int W_REQ = 0, W_ACK = 1, W_RESP = 2, W_GOIDLE = 3;

    logic        CLK_PAD_IO = 1'b0;
    logic        RST_PAD_I;
    logic        cmd_push, data_read, data_write, ack_in, req_in, card_detect;
    logic [31:0] cmd_arg;
    logic [13:0] cmd_set;
    logic [15:0] TIMEOUT_REG;
    logic [7:0]  serial_status;
    logic [39:0] cmd_in;
    logic        q_full, req_out, ack_out, resp_valid, go_idle_o, card_present;
    logic [2:0]  q_level;
    logic [39:0] cmd_out;
    logic [15:0] settings;
    logic [31:0] resp_data;
    logic [5:0]  resp_index;
    logic [4:0]  err_flags;

    always #5 CLK_PAD_IO = ~CLK_PAD_IO;

    sd_cmd_master_queued #(.QDEPTH(4), .TO_W(16), .SYNC_STAGES(2), .DEB_W(4), .MAX_RETRY(2)) dut (
        .CLK_PAD_IO(CLK_PAD_IO), .RST_PAD_I(RST_PAD_I), .cmd_push(cmd_push), .cmd_arg(cmd_arg),
        .cmd_set(cmd_set), .data_read(data_read), .data_write(data_write),
        .TIMEOUT_REG(TIMEOUT_REG), .q_full(q_full), .q_level(q_level), .cmd_out(cmd_out),
        .settings(settings), .req_out(req_out), .ack_in(ack_in), .req_in(req_in),
        .ack_out(ack_out), .serial_status(serial_status), .cmd_in(cmd_in),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_index(resp_index),
        .err_flags(err_flags), .go_idle_o(go_idle_o), .card_detect(card_detect),
        .card_present(card_present)
    );

    typedef struct {
        logic [39:0] cmd;
        logic [15:0] set;
        logic [5:0]  idx;
        logic [31:0] data;
        logic [4:0]  err;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic probe(input int w);
        case (w)
            W_REQ:   return req_out;
            W_ACK:   return ack_out;
            W_RESP:  return resp_valid;
            default: return go_idle_o;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input logic lvl, input int budget,
                            output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i <= budget; i++) begin
            if (probe(w) === lvl) begin
                found  = 1'b1;
                cycles = i;
                break;
            end
            if (i < budget) @(negedge CLK_PAD_IO);
        end
        check({tag, " reached"}, 64'(found), 64'd1);
    endtask

    function automatic logic [6:0] rsz(input logic [1:0] rts);
        return (rts == 2'b00) ? 7'd0 : (rts == 2'b01) ? 7'd127 : 7'd40;
    endfunction

    task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] wsel,
                            input logic cice, input logic crce, input logic [1:0] rts,
                            input logic rd, input logic wr, input logic [31:0] eng_data,
                            input logic [4:0] err_exp, input bit accepted);
        exp_t e;
        cmd_set    = {idx, wsel, 1'b1, cice, crce, 1'b1, rts};
        cmd_arg    = arg;
        data_read  = rd;
        data_write = wr;
        cmd_push   = 1'b1;
        if (accepted) begin
            e.cmd  = {2'b01, idx, arg};
            e.set  = {1'b0, wsel, rd, wr, 3'b111, crce, rsz(rts)};
            e.idx  = idx;
            e.data = (rts == 2'b00) ? 32'd0 : eng_data;
            e.err  = err_exp;
            sb.push_back(e);
        end
        @(negedge CLK_PAD_IO);
        cmd_push = 1'b0;
    endtask

    task automatic engine_accept();
        int c;
        wait_for("req_out rise", W_REQ, 1'b1, 40, c);
        if (sb.size() != 0) begin
            check("cmd_out", 64'(cmd_out), 64'(sb[0].cmd));
            check("settings", 64'(settings), 64'(sb[0].set));
        end
        ack_in = 1'b1;
        wait_for("req_out fall", W_REQ, 1'b0, 40, c);
        ack_in = 1'b0;
    endtask

    task automatic engine_respond(input logic [7:0] st, input logic [39:0] resp);
        int c;
        serial_status = st;
        cmd_in        = resp;
        req_in        = 1'b1;
        wait_for("ack_out rise", W_ACK, 1'b1, 40, c);
        req_in = 1'b0;
        wait_for("ack_out fall", W_ACK, 1'b0, 40, c);
    endtask

    task automatic expect_done(input int lvl);
        int   c;
        exp_t e;
        e = '{default: '0};
        wait_for("resp_valid", W_RESP, 1'b1, 60, c);
        if (sb.size() != 0) e = sb.pop_front();
        check("resp_index", 64'(resp_index), 64'(e.idx));
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("err_flags", 64'(err_flags), 64'(e.err));
        check("q_level at done", 64'(q_level), 64'(lvl));
        @(negedge CLK_PAD_IO);
        check("resp_valid pulse", 64'(resp_valid), 64'd0);
        check("q_level after pop", 64'(q_level), 64'(lvl - 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " q_level"}, 64'(q_level), 64'd0);
        check({tag, " q_full"}, 64'(q_full), 64'd0);
        check({tag, " handshake"}, 64'({req_out, ack_out, resp_valid, go_idle_o}), 64'd0);
        check({tag, " cmd_out"}, 64'(cmd_out), 64'd0);
        check({tag, " settings"}, 64'(settings), 64'd0);
        check({tag, " resp"}, 64'({resp_data, resp_index, err_flags}), 64'd0);
        check({tag, " card_present"}, 64'(card_present), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int c;
        RST_PAD_I = 1'b1; cmd_push = 1'b0; cmd_arg = '0; cmd_set = '0; data_read = 1'b0;
        data_write = 1'b0; TIMEOUT_REG = 16'd1000; ack_in = 1'b0; req_in = 1'b0;
        serial_status = '0; cmd_in = '0; card_detect = 1'b1;
        repeat (3) @(negedge CLK_PAD_IO);
        check_all_zero("reset");
        RST_PAD_I = 1'b0;
        @(negedge CLK_PAD_IO);

        // 1) single command, push-to-request latency and response capture
        push_cmd(6'd17, 32'h1234_5678, 2'b01, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 32'hCAFE_F00D, 5'd0, 1);
        check("latency req_out low", 64'(req_out), 64'd0);
        check("q_level one", 64'(q_level), 64'd1);
        @(negedge CLK_PAD_IO);
        check("latency req_out high", 64'(req_out), 64'd1);
        check("cmd_out literal", 64'(cmd_out), 64'h51_1234_5678);
        check("resp size 40", 64'(settings[6:0]), 64'd40);
        engine_accept();
        engine_respond(8'h60, {2'b00, 6'd17, 32'hCAFE_F00D});
        expect_done(1);

        // 2) fill the queue, drop a fifth push, drain in FIFO order
        for (int i = 0; i < 4; i++)
            push_cmd(6'(i + 1), 32'hA000_0000 | 32'(i), 2'(i), 1'b0, 1'b0, 2'(i), i[0], i[1],
                     32'hD000_0000 + 32'(i), 5'd0, 1);
        check("q_full set", 64'(q_full), 64'd1);
        check("q_level four", 64'(q_level), 64'd4);
        push_cmd(6'd50, 32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0, 5'd0, 0);
        check("q_level after drop", 64'(q_level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            engine_accept();
            engine_respond(8'h60, {2'b00, 6'(i + 1), 32'hD000_0000 + 32'(i)});
            expect_done(4 - i);
        end

        // 3a) two CRC failures then a good response
        push_cmd(6'd9, 32'h0000_0099, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'hBEEF_0001, 5'd0, 1);
        engine_accept();
        engine_respond(8'h40, {2'b00, 6'd9, 32'hBAD0_0000});
        check("no resp on retry 1", 64'(resp_valid), 64'd0);
        engine_accept();
        engine_respond(8'h40, {2'b00, 6'd9, 32'hBAD0_0000});
        check("no resp on retry 2", 64'(resp_valid), 64'd0);
        engine_accept();
        engine_respond(8'h60, {2'b00, 6'd9, 32'hBEEF_0001});
        expect_done(1);

        // 3b) retries exhausted
        push_cmd(6'd10, 32'h0000_00AA, 2'b10, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'hBAD0_0003, 5'b10010, 1);
        for (int i = 1; i <= 3; i++) begin
            engine_accept();
            engine_respond(8'h40, {2'b00, 6'd10, 32'hBAD0_0000 + 32'(i)});
        end
        expect_done(1);

        // 4) watchdog expiry with no status from the engine
        TIMEOUT_REG = 16'd10;
        push_cmd(6'd33, 32'h0BAD_CAFE, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0, 5'b00001, 1);
        engine_accept();
        wait_for("go_idle_o", W_GOIDLE, 1'b1, 40, c);
        check("watchdog cycles", 64'(c), 64'd11);
        check("req/ack low on expiry", 64'({req_out, ack_out}), 64'd0);
        @(negedge CLK_PAD_IO);
        check("go_idle pulse", 64'(go_idle_o), 64'd0);
        check("resp after timeout", 64'(resp_valid), 64'd1);
        expect_done(1);
        TIMEOUT_REG = 16'd1000;

        // 5) index mismatch with CICE, no retry
        push_cmd(6'd17, 32'h0000_5555, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_00A5, 5'b01000, 1);
        engine_accept();
        engine_respond(8'h40, {2'b00, 6'd5, 32'h0000_00A5});
        check("index error immediate resp", 64'(resp_valid), 64'd1);
        expect_done(1);

        // 6) asynchronous reset mid-EXECUTE with two entries held
        push_cmd(6'd20, 32'h2020_2020, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0, 5'd0, 1);
        push_cmd(6'd21, 32'h2121_2121, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0, 5'd0, 1);
        engine_accept();
        repeat (5) @(negedge CLK_PAD_IO);
        check("q_level before reset", 64'(q_level), 64'd2);
        RST_PAD_I = 1'b1;
        #1;
        check_all_zero("async reset");
        sb.delete();
        @(negedge CLK_PAD_IO);
        RST_PAD_I = 1'b0;
        repeat (4) @(negedge CLK_PAD_IO);
        check("idle after reset", 64'({req_out, q_level}), 64'd0);

        // card-detect debounce
        card_detect = 1'b0;
        repeat (15) @(negedge CLK_PAD_IO);
        check("card_present at 15", 64'(card_present), 64'd0);
        @(negedge CLK_PAD_IO);
        check("card_present at 16", 64'(card_present), 64'd1);
        card_detect = 1'b1;
        @(negedge CLK_PAD_IO);
        check("card_present holds", 64'(card_present), 64'd1);
        @(negedge CLK_PAD_IO);
        check("card_present clears", 64'(card_present), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
